// File: rtl/yaw_rate_limiter.sv
// Purpose: P-gain yaw angle error to a rate target, then clamp, slew-limit and idle-throttle gate it.
// Latency: accept at edge N -> SCALE/CLAMP/SLEW active N+1..N+3, target and complete pulse in N+4.
// Backpressure: none; starts arriving while busy are dropped, and a held start gives one update only.
`ifndef RATE_BIT_WIDTH
`define RATE_BIT_WIDTH 16
`endif
`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 8
`endif

module yaw_rate_limiter #(
    parameter logic [7:0] KP            = 8'd3,
    parameter int         KP_SHIFT      = 2,
    parameter int         MAX_RATE      = 1600,
    parameter int         SLEW_STEP     = 160,
    parameter int         THROTTLE_IDLE = 10
) (
    input  logic                                us_clk,
    input  logic                                resetn,
    input  logic                                start_signal,
    input  logic signed [`RATE_BIT_WIDTH-1:0]   yaw_angle_error,
    input  logic [`REC_VAL_BIT_WIDTH-1:0]       throttle_pwm_value_input,
    output logic signed [`RATE_BIT_WIDTH-1:0]   yaw_rate_target,
    output logic                                active_signal,
    output logic                                complete_signal
);

    localparam int RW = `RATE_BIT_WIDTH;
    localparam int TW = `REC_VAL_BIT_WIDTH;
    // Product width: 16-bit error times 8-bit unsigned gain plus a sign bit.
    localparam int PW = RW + 9;
    localparam int SW = RW + 1;

    localparam logic signed [PW-1:0] MAX_P  = PW'(MAX_RATE);
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_RATE);
    localparam logic signed [SW-1:0] STEP_S = SW'(SLEW_STEP);
    localparam logic [TW-1:0]        IDLE_T = TW'(THROTTLE_IDLE);

    typedef enum logic [2:0] {
        WAITING  = 3'd0,
        SCALE    = 3'd1,
        CLAMP    = 3'd2,
        SLEW     = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                  start_q;
    logic                  armed;
    logic                  accept;
    logic signed [RW-1:0]  err_q;
    logic [TW-1:0]         thr_q;
    logic signed [PW-1:0]  scaled_q;
    logic signed [SW-1:0]  clamped_q;

    logic signed [PW-1:0]  err_ext;
    logic signed [PW-1:0]  kp_ext;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  shifted;
    logic signed [SW-1:0]  clamp_val;
    logic signed [SW-1:0]  prev;
    logic signed [SW-1:0]  slew_hi;
    logic signed [SW-1:0]  slew_lo;
    logic signed [SW-1:0]  slew_val;
    logic                  idle;

    // A start counts only on a fresh rising edge in WAITING, and only once start has been seen low since reset.
    assign accept = (state == WAITING) && start_signal && !start_q && armed;

    // Next-state logic: one accepted start walks the pipeline once, illegal codes fall back to WAITING.
    always_comb begin
        state_nxt = WAITING;
        case (state)
            WAITING:  state_nxt = accept ? SCALE : WAITING;
            SCALE:    state_nxt = CLAMP;
            CLAMP:    state_nxt = SLEW;
            SLEW:     state_nxt = COMPLETE;
            COMPLETE: state_nxt = WAITING;
            default:  state_nxt = WAITING;
        endcase
    end

    // Datapath: signed gain multiply with floor shift, symmetric clamp, slew window around the previous target.
    always_comb begin
        err_ext   = {{(PW-RW){err_q[RW-1]}}, err_q};
        kp_ext    = {{(PW-8){1'b0}}, KP};
        prod      = err_ext * kp_ext;
        shifted   = prod >>> KP_SHIFT;

        clamp_val = scaled_q[SW-1:0];
        if (scaled_q > MAX_P) begin
            clamp_val = MAX_S;
        end else if (scaled_q < -MAX_P) begin
            clamp_val = -MAX_S;
        end

        prev      = {yaw_rate_target[RW-1], yaw_rate_target};
        slew_hi   = prev + STEP_S;
        slew_lo   = prev - STEP_S;
        slew_val  = clamped_q;
        if (clamped_q > slew_hi) begin
            slew_val = slew_hi;
        end else if (clamped_q < slew_lo) begin
            slew_val = slew_lo;
        end

        idle      = (thr_q < IDLE_T);
    end

    // State register plus registered handshakes decoded from the next state so they align with the state.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state           <= WAITING;
            active_signal   <= 1'b0;
            complete_signal <= 1'b0;
            start_q         <= 1'b0;
            armed           <= 1'b0;
        end else begin
            state           <= state_nxt;
            active_signal   <= (state_nxt == SCALE) || (state_nxt == CLAMP) || (state_nxt == SLEW);
            complete_signal <= (state_nxt == COMPLETE);
            start_q         <= start_signal;
            armed           <= armed | ~start_signal;
        end
    end

    // Pipeline registers: latch inputs on accept, advance one stage per state, commit target leaving SLEW.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            err_q           <= '0;
            thr_q           <= '0;
            scaled_q        <= '0;
            clamped_q       <= '0;
            yaw_rate_target <= '0;
        end else begin
            case (state)
                WAITING: begin
                    if (accept) begin
                        err_q <= yaw_angle_error;
                        thr_q <= throttle_pwm_value_input;
                    end
                end
                SCALE:   scaled_q  <= shifted;
                CLAMP:   clamped_q <= clamp_val;
                // Idle throttle forces zero so the next active update slews up from rest.
                SLEW:    yaw_rate_target <= idle ? '0 : slew_val[RW-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yaw_rate_limiter.sv
// Purpose: directed, table-driven check of yaw_rate_limiter scaling, clamp, slew, idle gating and handshakes.
// Latency: each update is driven and checked cycle by cycle on negedges.
// Backpressure: held and repeated starts, mid-op reset and held-through-reset start are exercised by hand.
module tb_yaw_rate_limiter;

    logic               us_clk;
    logic               resetn;
    logic               start_signal;
    logic signed [15:0] yaw_angle_error;
    logic [7:0]         throttle_pwm_value_input;
    logic signed [15:0] yaw_rate_target;
    logic               active_signal;
    logic               complete_signal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [15:0] err;
        logic [7:0]         thr;
        logic signed [15:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    yaw_rate_limiter dut (
        .us_clk                   (us_clk),
        .resetn                   (resetn),
        .start_signal             (start_signal),
        .yaw_angle_error          (yaw_angle_error),
        .throttle_pwm_value_input (throttle_pwm_value_input),
        .yaw_rate_target          (yaw_rate_target),
        .active_signal            (active_signal),
        .complete_signal          (complete_signal)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One start pulse; checks the active/complete timing and the committed, then held, target.
    task automatic run_update(input logic signed [15:0] err, input logic [7:0] thr,
                              input logic signed [15:0] exp, input string name);
        int hs_ok;
        int t_ok;
        @(negedge us_clk);
        yaw_angle_error          = err;
        throttle_pwm_value_input = thr;
        start_signal             = 1'b1;
        @(negedge us_clk);                       // SCALE
        start_signal = 1'b0;
        hs_ok = int'(active_signal && !complete_signal);
        @(negedge us_clk);                       // CLAMP
        hs_ok &= int'(active_signal && !complete_signal);
        @(negedge us_clk);                       // SLEW
        hs_ok &= int'(active_signal && !complete_signal);
        @(negedge us_clk);                       // COMPLETE
        hs_ok &= int'(!active_signal && complete_signal);
        t_ok = int'(yaw_rate_target == exp);
        @(negedge us_clk);                       // back in WAITING, target held
        hs_ok &= int'(!active_signal && !complete_signal);
        t_ok &= int'(yaw_rate_target == exp);
        chk({name, "_handshake"}, hs_ok, 1);
        chk({name, "_target"}, t_ok ? int'(exp) : int'(yaw_rate_target), int'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cmp;
        int n_act;
        int e;

        // Expected targets follow from error*3 >>> 2, clamp to +/-1600, slew of 160 from the previous target.
        vecs[0]  = '{16'sd160,   8'd100, 16'sd120};   // 480/4
        vecs[1]  = '{16'sd4000,  8'd9,   16'sd0};     // idle
        vecs[2]  = '{-16'sd3,    8'd100, -16'sd3};    // floor(-9/4)
        vecs[3]  = '{16'sd4000,  8'd9,   16'sd0};
        vecs[4]  = '{16'sd4000,  8'd100, 16'sd160};
        vecs[5]  = '{16'sd4000,  8'd100, 16'sd320};
        vecs[6]  = '{16'sd4000,  8'd100, 16'sd480};
        vecs[7]  = '{16'sd4000,  8'd100, 16'sd640};
        vecs[8]  = '{16'sd4000,  8'd100, 16'sd800};
        vecs[9]  = '{16'sd4000,  8'd9,   16'sd0};     // drops straight to 0
        vecs[10] = '{16'sd4000,  8'd10,  16'sd160};   // threshold counts as active
        vecs[11] = '{16'sd4000,  8'd9,   16'sd0};
        nvec = 12;
        for (int i = 0; i < 20; i++) begin
            e = -160 * (i + 1);
            if (e < -1600) e = -1600;
            vecs[nvec] = '{-16'sd32768, 8'd100, 16'(e)};
            nvec++;
        end

        resetn = 1'b0;
        start_signal = 1'b0;
        yaw_angle_error = '0;
        throttle_pwm_value_input = '0;
        repeat (3) @(negedge us_clk);
        chk("reset_target",   int'(yaw_rate_target), 0);
        chk("reset_active",   int'(active_signal), 0);
        chk("reset_complete", int'(complete_signal), 0);
        resetn = 1'b1;
        @(negedge us_clk);

        for (int i = 0; i < nvec; i++) begin
            run_update(vecs[i].err, vecs[i].thr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Start held high for 20 cycles: one update, -1600 slews toward 0 by one step.
        n_cmp = 0;
        n_act = 0;
        @(negedge us_clk);
        yaw_angle_error = 16'sd0;
        throttle_pwm_value_input = 8'd100;
        start_signal = 1'b1;
        repeat (20) begin
            @(negedge us_clk);
            n_cmp += int'(complete_signal);
            n_act += int'(active_signal);
        end
        start_signal = 1'b0;
        repeat (3) @(negedge us_clk);
        chk("held_complete_count", n_cmp, 1);
        chk("held_active_cycles",  n_act, 3);
        chk("held_target", int'(yaw_rate_target), -1440);

        // Second rising edge while busy is dropped, not queued.
        n_cmp = 0;
        @(negedge us_clk);
        start_signal = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge us_clk);
            if (k == 0) start_signal = 1'b0;
            if (k == 1) start_signal = 1'b1;
            if (k == 8) start_signal = 1'b0;
            n_cmp += int'(complete_signal);
        end
        chk("busy_edge_complete_count", n_cmp, 1);
        chk("busy_edge_target", int'(yaw_rate_target), -1280);

        // Reset during CLAMP aborts the update.
        @(negedge us_clk);
        start_signal = 1'b1;
        @(negedge us_clk);                       // SCALE
        start_signal = 1'b0;
        @(negedge us_clk);                       // CLAMP
        resetn = 1'b0;
        @(negedge us_clk);
        resetn = 1'b1;
        chk("midreset_target", int'(yaw_rate_target), 0);
        chk("midreset_handshake", int'(active_signal) + int'(complete_signal), 0);
        n_cmp = 0;
        n_act = 0;
        repeat (8) begin
            @(negedge us_clk);
            n_cmp += int'(complete_signal);
            n_act += int'(active_signal);
        end
        chk("midreset_no_complete", n_cmp + n_act, 0);
        run_update(16'sd160, 8'd100, 16'sd120, "post_reset");

        // Start already high across reset release is ignored until it has been low.
        @(negedge us_clk);
        resetn = 1'b0;
        start_signal = 1'b1;
        @(negedge us_clk);
        resetn = 1'b1;
        n_cmp = 0;
        n_act = 0;
        repeat (10) begin
            @(negedge us_clk);
            n_cmp += int'(complete_signal);
            n_act += int'(active_signal);
        end
        chk("held_through_reset_ignored", n_cmp + n_act, 0);
        start_signal = 1'b0;
        @(negedge us_clk);
        run_update(16'sd4000, 8'd100, 16'sd160, "after_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
